// File: rtl/mem_access_ctrl.sv
// Data-memory sequencing controller: classifies a load/store, then runs a req/ack access or raises a fault.
// Optional FAULT_COUNT_EN builds a saturating 8-bit fault counter on fault_count.
module mem_access_ctrl #(
  parameter int ADDR_LIMIT = 128,
  parameter int AW         = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic [31:0]   aluout,
  input  logic [1:0]    writecontrol,
  input  logic [1:0]    readcontrol,
  input  logic          luiout,
  input  logic [31:0]   wdata,
  output logic          stall,
  output logic          done,
  output logic [31:0]   rdata,
  output logic          exc,
  output logic [1:0]    cause,
  output logic [31:0]   badaddr,
  output logic          mem_en,
  output logic          mem_we,
  output logic [1:0]    mem_size,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_ack,
  output logic [7:0]    fault_count
);

  typedef enum logic [2:0] {IDLE, CHECK, ACCESS, DONE, FAULT} state_t;

  localparam logic [31:0] LIMIT = ADDR_LIMIT;

  state_t      state, next_state;
  logic        noop;
  logic [31:0] addr_q, wdata_q;
  logic [1:0]  wc_q, rc_q;
  logic [1:0]  check_cause;

  assign noop = luiout | ((writecontrol == 2'd3) & (readcontrol == 2'd3));

  // Unsigned compare folds the negative (signed) and >= limit checks into one.
  always_comb begin
    check_cause = 2'd0;
    if (wc_q != 2'd3 && rc_q != 2'd3)
      check_cause = 2'd3;
    else if ((wc_q == 2'd2 && addr_q[1:0] != 2'd0) || (wc_q == 2'd1 && addr_q[0]))
      check_cause = 2'd2;
    else if ((rc_q == 2'd2 && addr_q[1:0] != 2'd0) || (rc_q == 2'd1 && addr_q[0]))
      check_cause = 2'd1;
    else if (addr_q >= LIMIT)
      check_cause = 2'd3;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req) next_state = noop ? DONE : CHECK;
      CHECK:   next_state = (check_cause != 2'd0) ? FAULT : ACCESS;
      ACCESS:  if (mem_ack) next_state = DONE;
      DONE:    next_state = IDLE;
      FAULT:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    stall = ~rst & (((state == IDLE) & req & ~noop) | (state == CHECK) | (state == ACCESS));
    done  = (state == DONE) | (state == FAULT);
    exc   = (state == FAULT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      wc_q      <= '0;
      rc_q      <= '0;
      cause     <= '0;
      badaddr   <= '0;
      rdata     <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_size  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if (state == IDLE && req && !noop) begin
        addr_q  <= aluout;
        wdata_q <= wdata;
        wc_q    <= writecontrol;
        rc_q    <= readcontrol;
      end
      if (state == CHECK) begin
        if (check_cause != 2'd0) begin
          cause   <= check_cause;
          badaddr <= addr_q;
        end else begin
          mem_en    <= 1'b1;
          mem_we    <= (wc_q != 2'd3);
          mem_size  <= (wc_q != 2'd3) ? wc_q : rc_q;
          mem_addr  <= addr_q[AW-1:0];
          mem_wdata <= wdata_q;
        end
      end
      if (state == ACCESS && mem_ack) begin
        mem_en <= 1'b0;
        if (!mem_we) rdata <= mem_rdata;
      end
    end
  end

`ifdef FAULT_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      fault_count <= '0;
    else if (state == CHECK && check_cause != 2'd0 && fault_count != 8'hFF)
      fault_count <= fault_count + 8'd1;
  end
`else
  assign fault_count = '0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed table, random requests vs. a rule-level model, reset abort, fault counter.
module tb_mem_access_ctrl;

  localparam int LIM = 128;

  logic        clk = 1'b0;
  logic        rst, req, luiout, mem_ack;
  logic [31:0] aluout, wdata, mem_rdata;
  logic [1:0]  writecontrol, readcontrol;
  logic        stall, done, exc, mem_en, mem_we;
  logic [31:0] rdata, badaddr, mem_wdata;
  logic [1:0]  cause, mem_size;
  logic [6:0]  mem_addr;
  logic [7:0]  fault_count;

  int errors = 0;
  int checks = 0;
  int faults_since_reset = 0;

  mem_access_ctrl #(.ADDR_LIMIT(128), .AW(7)) dut (
    .clk(clk), .rst(rst), .req(req), .aluout(aluout), .writecontrol(writecontrol),
    .readcontrol(readcontrol), .luiout(luiout), .wdata(wdata), .stall(stall), .done(done),
    .rdata(rdata), .exc(exc), .cause(cause), .badaddr(badaddr), .mem_en(mem_en),
    .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .fault_count(fault_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  wc, rc;
    logic        lui;
    int          delay;
    logic [31:0] rd, wd;
    int          exp_done;
    logic        exp_exc;
    logic [1:0]  exp_cause;
  } vec_t;

  typedef struct {
    int          done_cyc;
    logic        exc;
    logic [1:0]  cause;
    logic [31:0] badaddr, rdata;
    int          en_first, en_cnt;
    logic        we;
    logic [6:0]  maddr;
    logic [1:0]  size;
    logic [31:0] mwdata;
    logic [63:0] stall_mask;
  } obs_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference classification straight from the access rules.
  function automatic logic [1:0] model_cause(logic [31:0] a, logic [1:0] wc, logic [1:0] rc);
    int unsigned m;
    m = a % 4;
    if (wc != 2'd3 && rc != 2'd3) return 2'd3;
    if ((wc == 2'd2 && m != 0) || (wc == 2'd1 && (m == 1 || m == 3))) return 2'd2;
    if ((rc == 2'd2 && m != 0) || (rc == 2'd1 && (m == 1 || m == 3))) return 2'd1;
    if ($signed(a) < 0 || $signed(a) >= LIM) return 2'd3;
    return 2'd0;
  endfunction

  task automatic run_req(input vec_t v, output obs_t o);
    int waits;
    waits = 0;
    o.done_cyc = -1; o.exc = 0; o.cause = 0; o.badaddr = 0; o.rdata = 0;
    o.en_first = -1; o.en_cnt = 0; o.we = 0; o.maddr = 0; o.size = 0; o.mwdata = 0;
    o.stall_mask = '0;
    @(posedge clk); #1;
    req = 1'b1; aluout = v.addr; writecontrol = v.wc; readcontrol = v.rc;
    luiout = v.lui; wdata = v.wd; mem_rdata = v.rd;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (mem_en) begin
        mem_ack = (waits >= v.delay);
        waits++;
      end else begin
        mem_ack = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      if (stall) o.stall_mask[c] = 1'b1;
      if (mem_en) begin
        if (o.en_first < 0) o.en_first = c;
        o.en_cnt++;
        o.we = mem_we; o.maddr = mem_addr; o.size = mem_size; o.mwdata = mem_wdata;
      end
      if (done) begin
        o.done_cyc = c; o.exc = exc; o.cause = cause; o.badaddr = badaddr; o.rdata = rdata;
        break;
      end
    end
    req = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic judge(input string tag, input vec_t v, input obs_t o,
                       input int exp_done, input logic exp_exc, input logic [1:0] exp_cause);
    bit noop, legal;
    noop  = v.lui || (v.wc == 2'd3 && v.rc == 2'd3);
    legal = !noop && !exp_exc;
    if (exp_exc) faults_since_reset++;
    check({tag, " done_cycle"}, o.done_cyc, exp_done);
    check({tag, " exc"}, o.exc, exp_exc);
    check({tag, " stall_mask"}, o.stall_mask, noop ? 64'd0 : ((64'd1 << exp_done) - 64'd1));
    check({tag, " mem_en_cycles"}, o.en_cnt, legal ? v.delay + 1 : 0);
    if (exp_exc) begin
      check({tag, " cause"}, o.cause, exp_cause);
      check({tag, " badaddr"}, o.badaddr, v.addr);
    end
    if (legal) begin
      check({tag, " mem_en_first"}, o.en_first, 2);
      check({tag, " mem_we"}, o.we, v.wc != 2'd3);
      check({tag, " mem_addr"}, o.maddr, v.addr[6:0]);
      check({tag, " mem_size"}, o.size, (v.wc != 2'd3) ? v.wc : v.rc);
      if (v.wc != 2'd3) check({tag, " mem_wdata"}, o.mwdata, v.wd);
      else              check({tag, " rdata"}, o.rdata, v.rd);
    end
  endtask

  initial begin
    vec_t tbl[14];
    vec_t v;
    obs_t o;
    logic [1:0] ec;
    bit saw_done, saw_en;

    tbl[0]  = '{32'd8,          2'd2, 2'd3, 1'b0, 0, 32'h0,        32'h1234_5678, 3, 1'b0, 2'd0};
    tbl[1]  = '{32'd6,          2'd3, 2'd2, 1'b0, 0, 32'h0,        32'h0,         2, 1'b1, 2'd1};
    tbl[2]  = '{32'd2,          2'd1, 2'd3, 1'b0, 1, 32'h0,        32'h0000_BEEF, 4, 1'b0, 2'd0};
    tbl[3]  = '{32'd3,          2'd1, 2'd3, 1'b0, 0, 32'h0,        32'h0,         2, 1'b1, 2'd2};
    tbl[4]  = '{32'd3,          2'd3, 2'd0, 1'b0, 0, 32'h0000_00A5, 32'h0,        3, 1'b0, 2'd0};
    tbl[5]  = '{32'd128,        2'd3, 2'd0, 1'b0, 0, 32'h0,        32'h0,         2, 1'b1, 2'd3};
    tbl[6]  = '{32'hFFFF_FFFC,  2'd2, 2'd3, 1'b0, 0, 32'h0,        32'h0,         2, 1'b1, 2'd3};
    tbl[7]  = '{32'd130,        2'd2, 2'd3, 1'b0, 0, 32'h0,        32'h0,         2, 1'b1, 2'd2};
    tbl[8]  = '{32'd8,          2'd2, 2'd2, 1'b0, 0, 32'h0,        32'h0,         2, 1'b1, 2'd3};
    tbl[9]  = '{32'd4,          2'd3, 2'd2, 1'b0, 4, 32'hDEAD_BEEF, 32'h0,        7, 1'b0, 2'd0};
    tbl[10] = '{32'd200,        2'd2, 2'd3, 1'b1, 0, 32'h0,        32'h0,         1, 1'b0, 2'd0};
    tbl[11] = '{32'd5,          2'd3, 2'd3, 1'b0, 0, 32'h0,        32'h0,         1, 1'b0, 2'd0};
    tbl[12] = '{32'd127,        2'd0, 2'd3, 1'b0, 2, 32'h0,        32'h0000_00C3, 5, 1'b0, 2'd0};
    tbl[13] = '{32'd126,        2'd3, 2'd1, 1'b0, 0, 32'h0000_7777, 32'h0,        3, 1'b0, 2'd0};

    rst = 1'b1; req = 1'b0; luiout = 1'b0; mem_ack = 1'b0;
    aluout = '0; wdata = '0; mem_rdata = '0; writecontrol = 2'd3; readcontrol = 2'd3;
    repeat (2) @(posedge clk);
    #1;
    check("reset stall", stall, 0);
    check("reset done", done, 0);
    check("reset exc", exc, 0);
    check("reset mem_en", mem_en, 0);
    check("reset cause", cause, 0);
    check("reset badaddr", badaddr, 0);
    check("reset rdata", rdata, 0);
    check("reset fault_count", fault_count, 0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      run_req(tbl[i], o);
      judge($sformatf("vec%0d", i), tbl[i], o, tbl[i].exp_done, tbl[i].exp_exc, tbl[i].exp_cause);
    end

    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 3))
        0: v.addr = $urandom_range(0, LIM - 1);
        1: v.addr = $urandom_range(LIM - 4, LIM + 8);
        2: v.addr = $urandom;
        default: v.addr = 32'hFFFF_FFF0 + $urandom_range(0, 15);
      endcase
      v.wc = 2'($urandom_range(0, 3));
      v.rc = ($urandom_range(0, 1) == 0) ? 2'd3 : 2'($urandom_range(0, 3));
      if (v.rc != 2'd3 && $urandom_range(0, 3) != 0) v.wc = 2'd3;
      v.lui = ($urandom_range(0, 7) == 0);
      v.delay = $urandom_range(0, 3);
      v.rd = $urandom;
      v.wd = $urandom;
      ec = model_cause(v.addr, v.wc, v.rc);
      if (v.lui || (v.wc == 2'd3 && v.rc == 2'd3)) begin
        v.exp_done = 1; v.exp_exc = 1'b0; v.exp_cause = 2'd0;
      end else if (ec != 2'd0) begin
        v.exp_done = 2; v.exp_exc = 1'b1; v.exp_cause = ec;
      end else begin
        v.exp_done = 3 + v.delay; v.exp_exc = 1'b0; v.exp_cause = 2'd0;
      end
      run_req(v, o);
      judge($sformatf("rnd%0d", n), v, o, v.exp_done, v.exp_exc, v.exp_cause);
    end

    // Reset in the second wait cycle of a word read must abort without completion.
    @(posedge clk); #1;
    req = 1'b1; aluout = 32'd4; writecontrol = 2'd3; readcontrol = 2'd2; luiout = 1'b0;
    mem_ack = 1'b0; mem_rdata = 32'hDEAD_BEEF;
    repeat (3) begin @(posedge clk); #1; end
    check("abort pre mem_en", mem_en, 1);
    check("abort pre stall", stall, 1);
    rst = 1'b1;
    #1;
    check("abort mem_en", mem_en, 0);
    check("abort stall", stall, 0);
    check("abort done", done, 0);
    check("abort exc", exc, 0);
    check("abort cause", cause, 0);
    check("abort badaddr", badaddr, 0);
    check("abort rdata", rdata, 0);
    check("abort mem_we", mem_we, 0);
    check("abort mem_addr", mem_addr, 0);
    check("abort fault_count", fault_count, 0);
    faults_since_reset = 0;
    req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    saw_done = 1'b0; saw_en = 1'b0;
    mem_ack = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
      if (mem_en) saw_en = 1'b1;
    end
    mem_ack = 1'b0;
    check("abort no done", saw_done, 0);
    check("abort no mem_en", saw_en, 0);

    v = '{32'd6, 2'd3, 2'd2, 1'b0, 0, 32'h0, 32'h0, 2, 1'b1, 2'd1};
    for (int n = 0; n < 260; n++) begin
      run_req(v, o);
      judge($sformatf("flt%0d", n), v, o, 2, 1'b1, 2'd1);
    end
    @(negedge clk);
`ifdef FAULT_COUNT_EN
    check("fault_count", fault_count, (faults_since_reset > 255) ? 255 : faults_since_reset);
`else
    check("fault_count", fault_count, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
